// File: rtl/safe_lockstep_pkg.sv
// Shared types and encodings for the safe-wrapper lockstep sequencer.
package safe_lockstep_pkg;

  // Sequencer states, in the order a normal lockstep entry walks through them
  typedef enum logic [2:0] {
    IDLE,
    HALT,
    SYNC,
    RELEASE,
    RUN,
    DRAIN,
    FAULT
  } state_e;

  // Safe configuration encodings as written by software (2'b11 is reserved)
  localparam logic [1:0] SAFE_SINGLE = 2'b00;
  localparam logic [1:0] SAFE_TMR    = 2'b01;
  localparam logic [1:0] SAFE_DMR    = 2'b10;

  // Voter/comparator enable encodings
  localparam logic [1:0] LS_OFF = 2'b00;
  localparam logic [1:0] LS_TMR = 2'b01;
  localparam logic [1:0] LS_DMR = 2'b10;

  // Number of set bits in a three-hart mask
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/safe_lockstep_timer.sv
// Wait-state watchdog: clearable up-counter that flags expiry after
// TIMEOUT_CYCLES-1 counted cycles and then holds.
module safe_lockstep_timer #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_count;

  assign o_expired = (r_count == LAST);

  // Count while running; a clear (state entry) always restarts from zero
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_run && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/safe_lockstep_fsm.sv
// Lockstep sequencing FSM of the safe wrapper: halts the participating harts,
// lets the master save context, releases them into lockstep and drains back
// out, with a watchdog on every wait state and DMR recovery on mismatch.
module safe_lockstep_fsm
  import safe_lockstep_pkg::*;
#(
  parameter int NHARTS         = 3,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int ERRCNT_W       = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [2:0]          master_core_i,
  input  logic [2:0]          safe_mode_i,
  input  logic [1:0]          safe_configuration_i,
  input  logic                critical_section_i,
  input  logic                initial_sync_master_i,
  input  logic                start_i,
  input  logic                end_sw_routine_i,
  input  logic [NHARTS-1:0]   debug_mode_i,
  input  logic [NHARTS-1:0]   sleep_i,
  input  logic                dmr_error_i,
  input  logic                tmr_error_i,
  output logic [NHARTS-1:0]   debug_req_o,
  output logic [1:0]          lockstep_en_o,
  output logic                start_boot_o,
  output logic                en_ext_debug_o,
  output logic                dmr_rec_o,
  output logic                fault_o,
  output logic [ERRCNT_W-1:0] err_count_o
);

  state_e              r_state, w_next;
  logic [NHARTS-1:0]   r_mask, w_newMask;
  logic [1:0]          r_cfg, w_lsMode;
  logic                r_startQ, r_endQ, r_dmrQ, r_errQ;
  logic                r_fault, r_dmrRec;
  logic [ERRCNT_W-1:0] r_errCount;
  logic                w_startRise, w_endRise, w_dmrRise, w_errRise;
  logic                w_maskOk, w_timerRun, w_timerClear, w_expired;

  assign w_startRise = start_i & ~r_startQ;
  assign w_endRise   = end_sw_routine_i & ~r_endQ;
  assign w_dmrRise   = dmr_error_i & ~r_dmrQ;
  assign w_errRise   = (dmr_error_i | tmr_error_i) & ~r_errQ;

  // Participating-hart mask for the requested configuration and its validity
  always_comb begin
    w_newMask = master_core_i;
    w_maskOk  = (popcount3(master_core_i) == 2'd1);
    case (safe_configuration_i)
      SAFE_TMR: begin
        w_newMask = '1;
        w_maskOk  = 1'b1;
      end
      SAFE_DMR: begin
        w_newMask = safe_mode_i;
        w_maskOk  = (popcount3(safe_mode_i) == 2'd2);
      end
      default: ;
    endcase
  end

  // Next state: exit conditions are checked before the watchdog so a late exit still wins
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_startRise) w_next = w_maskOk ? HALT : FAULT;
      HALT:    if ((debug_mode_i & r_mask) == r_mask) w_next = SYNC;
               else if (w_expired) w_next = FAULT;
      SYNC:    if (initial_sync_master_i) w_next = RELEASE;
               else if (w_expired) w_next = FAULT;
      RELEASE: if ((debug_mode_i & r_mask) == '0) w_next = RUN;
               else if (w_expired) w_next = FAULT;
      RUN:     if (w_dmrRise && (r_cfg == SAFE_DMR)) w_next = HALT;
               else if (w_endRise) w_next = DRAIN;
      DRAIN:   if ((sleep_i & r_mask) == r_mask) w_next = IDLE;
               else if (w_expired) w_next = FAULT;
      FAULT:   if (!start_i) w_next = IDLE;
      default: w_next = FAULT;
    endcase
  end

  assign w_timerClear = (w_next != r_state);
  assign w_timerRun   = (r_state == HALT) || (r_state == SYNC) ||
                        (r_state == RELEASE) || (r_state == DRAIN);

  safe_lockstep_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .i_clear  (w_timerClear),
    .i_run    (w_timerRun),
    .o_expired(w_expired)
  );

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_next;
  end

  // Previous-cycle copies of the level inputs for rising-edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_startQ <= 1'b0;
      r_endQ   <= 1'b0;
      r_dmrQ   <= 1'b0;
      r_errQ   <= 1'b0;
    end else begin
      r_startQ <= start_i;
      r_endQ   <= end_sw_routine_i;
      r_dmrQ   <= dmr_error_i;
      r_errQ   <= dmr_error_i | tmr_error_i;
    end
  end

  // Capture mask and configuration once, when a start leaves IDLE
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_mask <= '0;
      r_cfg  <= SAFE_SINGLE;
    end else if ((r_state == IDLE) && w_startRise) begin
      r_mask <= w_newMask;
      r_cfg  <= safe_configuration_i;
    end
  end

  // Sticky fault flag and DMR-recovery flag (set on RUN->HALT, cleared on entering RUN)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_fault  <= 1'b0;
      r_dmrRec <= 1'b0;
    end else begin
      if (w_next == FAULT) r_fault <= 1'b1;
      if ((r_state == RUN) && (w_next == HALT)) r_dmrRec <= 1'b1;
      else if ((r_state != RUN) && (w_next == RUN)) r_dmrRec <= 1'b0;
    end
  end

  // Saturating count of error events; coincident DMR/TMR edges count once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_errCount <= '0;
    end else if (w_errRise && (r_errCount != '1)) begin
      r_errCount <= r_errCount + 1'b1;
    end
  end

  assign w_lsMode = (r_cfg == SAFE_TMR) ? LS_TMR :
                    (r_cfg == SAFE_DMR) ? LS_DMR : LS_OFF;

  // Moore output decode from the registered state
  always_comb begin
    debug_req_o   = '0;
    lockstep_en_o = LS_OFF;
    start_boot_o  = 1'b0;
    case (r_state)
      HALT: debug_req_o = r_mask;
      SYNC: begin
        debug_req_o  = r_mask;
        start_boot_o = 1'b1;
      end
      RUN, DRAIN: lockstep_en_o = w_lsMode;
      default: ;
    endcase
  end

  assign en_ext_debug_o = (r_state == IDLE) && !critical_section_i;
  assign dmr_rec_o      = r_dmrRec;
  assign fault_o        = r_fault;
  assign err_count_o    = r_errCount;

endmodule

// File: tb/tb_safe_lockstep_fsm.sv
// Directed bench for safe_lockstep_fsm: a cycle-by-cycle vector table for the
// TMR and DMR flows, plus hand sequences for faults, timeout, saturation and reset.
module tb_safe_lockstep_fsm;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [2:0] master_core_i, safe_mode_i;
  logic [1:0] safe_configuration_i;
  logic       critical_section_i, initial_sync_master_i, start_i, end_sw_routine_i;
  logic [2:0] debug_mode_i, sleep_i;
  logic       dmr_error_i, tmr_error_i;
  logic [2:0] debug_req_o;
  logic [1:0] lockstep_en_o;
  logic       start_boot_o, en_ext_debug_o, dmr_rec_o, fault_o;
  logic [7:0] err_count_o;

  int nVectors = 0;
  int nMiscompares = 0;

  typedef struct {
    string      name;
    logic [1:0] cfg;
    logic [2:0] sm, mc;
    logic       crit, start, endr, isync;
    logic [2:0] dbg, slp;
    logic       dmrE, tmrE;
    logic [2:0] eReq;
    logic [1:0] eLe;
    logic       eBoot, eExt, eRec, eFault;
    logic [7:0] eErr;
  } vec_t;

  vec_t tbl[$];

  safe_lockstep_fsm #(
    .NHARTS(3), .TIMEOUT_CYCLES(16), .ERRCNT_W(8)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .master_core_i(master_core_i), .safe_mode_i(safe_mode_i),
    .safe_configuration_i(safe_configuration_i),
    .critical_section_i(critical_section_i),
    .initial_sync_master_i(initial_sync_master_i),
    .start_i(start_i), .end_sw_routine_i(end_sw_routine_i),
    .debug_mode_i(debug_mode_i), .sleep_i(sleep_i),
    .dmr_error_i(dmr_error_i), .tmr_error_i(tmr_error_i),
    .debug_req_o(debug_req_o), .lockstep_en_o(lockstep_en_o),
    .start_boot_o(start_boot_o), .en_ext_debug_o(en_ext_debug_o),
    .dmr_rec_o(dmr_rec_o), .fault_o(fault_o), .err_count_o(err_count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic addVec(input string nm, input logic [1:0] cfg, input logic [2:0] sm, mc,
                        input logic crit, start, endr, isync, input logic [2:0] dbg, slp,
                        input logic dmrE, tmrE, input logic [2:0] eReq, input logic [1:0] eLe,
                        input logic eBoot, eExt, eRec, eFault, input logic [7:0] eErr);
    vec_t v;
    v.name = nm; v.cfg = cfg; v.sm = sm; v.mc = mc; v.crit = crit; v.start = start;
    v.endr = endr; v.isync = isync; v.dbg = dbg; v.slp = slp; v.dmrE = dmrE; v.tmrE = tmrE;
    v.eReq = eReq; v.eLe = eLe; v.eBoot = eBoot; v.eExt = eExt; v.eRec = eRec;
    v.eFault = eFault; v.eErr = eErr;
    tbl.push_back(v);
  endtask

  task automatic clearInputs();
    master_core_i = 3'b001; safe_mode_i = 3'b000; safe_configuration_i = 2'b01;
    critical_section_i = 1'b0; initial_sync_master_i = 1'b0; start_i = 1'b0;
    end_sw_routine_i = 1'b0; debug_mode_i = 3'b000; sleep_i = 3'b000;
    dmr_error_i = 1'b0; tmr_error_i = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    safe_configuration_i = v.cfg; safe_mode_i = v.sm; master_core_i = v.mc;
    critical_section_i = v.crit; start_i = v.start; end_sw_routine_i = v.endr;
    initial_sync_master_i = v.isync; debug_mode_i = v.dbg; sleep_i = v.slp;
    dmr_error_i = v.dmrE; tmr_error_i = v.tmrE;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic resetDut();
    rst_ni = 1'b0;
    clearInputs();
    step();
    rst_ni = 1'b1;
  endtask

  task automatic checkOutput(input string nm, input logic [2:0] eReq, input logic [1:0] eLe,
                             input logic eBoot, eExt, eRec, eFault, input logic [7:0] eErr);
    nVectors++;
    if (debug_req_o !== eReq) begin
      nMiscompares++;
      $display("[TB] FAIL %s debug_req_o got %b expected %b", nm, debug_req_o, eReq);
    end
    if (lockstep_en_o !== eLe) begin
      nMiscompares++;
      $display("[TB] FAIL %s lockstep_en_o got %b expected %b", nm, lockstep_en_o, eLe);
    end
    if (start_boot_o !== eBoot) begin
      nMiscompares++;
      $display("[TB] FAIL %s start_boot_o got %b expected %b", nm, start_boot_o, eBoot);
    end
    if (en_ext_debug_o !== eExt) begin
      nMiscompares++;
      $display("[TB] FAIL %s en_ext_debug_o got %b expected %b", nm, en_ext_debug_o, eExt);
    end
    if (dmr_rec_o !== eRec) begin
      nMiscompares++;
      $display("[TB] FAIL %s dmr_rec_o got %b expected %b", nm, dmr_rec_o, eRec);
    end
    if (fault_o !== eFault) begin
      nMiscompares++;
      $display("[TB] FAIL %s fault_o got %b expected %b", nm, fault_o, eFault);
    end
    if (err_count_o !== eErr) begin
      nMiscompares++;
      $display("[TB] FAIL %s err_count_o got %0d expected %0d", nm, err_count_o, eErr);
    end
  endtask

  initial begin
    clearInputs();
    rst_ni = 1'b0;

    // name cfg sm mc crit start end isync dbg slp dmrE tmrE | req le boot ext rec fault err
    addVec("idle",     2'b01,3'b000,3'b001,1'b0,1'b0,1'b0,1'b0,3'b000,3'b000,1'b0,1'b0, 3'b000,2'b00,1'b0,1'b1,1'b0,1'b0,8'd0);
    addVec("start",    2'b01,3'b000,3'b001,1'b0,1'b1,1'b0,1'b0,3'b000,3'b000,1'b0,1'b0, 3'b111,2'b00,1'b0,1'b0,1'b0,1'b0,8'd0);
    addVec("halt1",    2'b01,3'b000,3'b001,1'b0,1'b1,1'b0,1'b0,3'b000,3'b000,1'b0,1'b0, 3'b111,2'b00,1'b0,1'b0,1'b0,1'b0,8'd0);
    addVec("halt2",    2'b01,3'b000,3'b001,1'b0,1'b0,1'b0,1'b0,3'b000,3'b000,1'b0,1'b0, 3'b111,2'b00,1'b0,1'b0,1'b0,1'b0,8'd0);
    addVec("toSync",   2'b01,3'b000,3'b001,1'b0,1'b0,1'b0,1'b0,3'b111,3'b000,1'b0,1'b0, 3'b111,2'b00,1'b1,1'b0,1'b0,1'b0,8'd0);
    addVec("sync",     2'b01,3'b000,3'b001,1'b0,1'b0,1'b0,1'b0,3'b111,3'b000,1'b0,1'b0, 3'b111,2'b00,1'b1,1'b0,1'b0,1'b0,8'd0);
    addVec("toRel",    2'b01,3'b000,3'b001,1'b0,1'b0,1'b0,1'b1,3'b111,3'b000,1'b0,1'b0, 3'b000,2'b00,1'b0,1'b0,1'b0,1'b0,8'd0);
    addVec("rel",      2'b01,3'b000,3'b001,1'b0,1'b0,1'b0,1'b0,3'b111,3'b000,1'b0,1'b0, 3'b000,2'b00,1'b0,1'b0,1'b0,1'b0,8'd0);
    addVec("toRun",    2'b01,3'b000,3'b001,1'b0,1'b0,1'b0,1'b0,3'b000,3'b000,1'b0,1'b0, 3'b000,2'b01,1'b0,1'b0,1'b0,1'b0,8'd0);
    addVec("startIgn", 2'b01,3'b000,3'b001,1'b0,1'b1,1'b0,1'b0,3'b000,3'b000,1'b0,1'b0, 3'b000,2'b01,1'b0,1'b0,1'b0,1'b0,8'd0);
    addVec("endRise",  2'b01,3'b000,3'b001,1'b0,1'b0,1'b1,1'b0,3'b000,3'b000,1'b0,1'b0, 3'b000,2'b01,1'b0,1'b0,1'b0,1'b0,8'd0);
    addVec("drainWait",2'b01,3'b000,3'b001,1'b0,1'b0,1'b1,1'b0,3'b000,3'b011,1'b0,1'b0, 3'b000,2'b01,1'b0,1'b0,1'b0,1'b0,8'd0);
    addVec("toIdle",   2'b01,3'b000,3'b001,1'b0,1'b0,1'b0,1'b0,3'b000,3'b111,1'b0,1'b0, 3'b000,2'b00,1'b0,1'b1,1'b0,1'b0,8'd0);
    addVec("critSec",  2'b01,3'b000,3'b001,1'b1,1'b0,1'b0,1'b0,3'b000,3'b000,1'b0,1'b0, 3'b000,2'b00,1'b0,1'b0,1'b0,1'b0,8'd0);
    addVec("dStart",   2'b10,3'b011,3'b001,1'b0,1'b1,1'b0,1'b0,3'b000,3'b000,1'b0,1'b0, 3'b011,2'b00,1'b0,1'b0,1'b0,1'b0,8'd0);
    addVec("dSync",    2'b10,3'b011,3'b001,1'b0,1'b0,1'b0,1'b0,3'b011,3'b000,1'b0,1'b0, 3'b011,2'b00,1'b1,1'b0,1'b0,1'b0,8'd0);
    addVec("dRel",     2'b10,3'b011,3'b001,1'b0,1'b0,1'b0,1'b1,3'b011,3'b000,1'b0,1'b0, 3'b000,2'b00,1'b0,1'b0,1'b0,1'b0,8'd0);
    addVec("dRun",     2'b10,3'b011,3'b001,1'b0,1'b0,1'b0,1'b0,3'b000,3'b000,1'b0,1'b0, 3'b000,2'b10,1'b0,1'b0,1'b0,1'b0,8'd0);
    addVec("dErrBoth", 2'b10,3'b011,3'b001,1'b0,1'b0,1'b0,1'b0,3'b000,3'b000,1'b1,1'b1, 3'b011,2'b00,1'b0,1'b0,1'b1,1'b0,8'd1);
    addVec("dHalt",    2'b10,3'b011,3'b001,1'b0,1'b0,1'b0,1'b0,3'b000,3'b000,1'b0,1'b0, 3'b011,2'b00,1'b0,1'b0,1'b1,1'b0,8'd1);
    addVec("dReSync",  2'b10,3'b011,3'b001,1'b0,1'b0,1'b0,1'b0,3'b011,3'b000,1'b0,1'b0, 3'b011,2'b00,1'b1,1'b0,1'b1,1'b0,8'd1);
    addVec("dReRel",   2'b10,3'b011,3'b001,1'b0,1'b0,1'b0,1'b1,3'b011,3'b000,1'b0,1'b0, 3'b000,2'b00,1'b0,1'b0,1'b1,1'b0,8'd1);
    addVec("dReRun",   2'b10,3'b011,3'b001,1'b0,1'b0,1'b0,1'b0,3'b000,3'b000,1'b0,1'b0, 3'b000,2'b10,1'b0,1'b0,1'b0,1'b0,8'd1);
    addVec("prioRec",  2'b10,3'b011,3'b001,1'b0,1'b0,1'b1,1'b0,3'b000,3'b000,1'b1,1'b0, 3'b011,2'b00,1'b0,1'b0,1'b1,1'b0,8'd2);
    addVec("pSync",    2'b10,3'b011,3'b001,1'b0,1'b0,1'b1,1'b0,3'b011,3'b000,1'b0,1'b0, 3'b011,2'b00,1'b1,1'b0,1'b1,1'b0,8'd2);
    addVec("pRel",     2'b10,3'b011,3'b001,1'b0,1'b0,1'b0,1'b1,3'b011,3'b000,1'b0,1'b0, 3'b000,2'b00,1'b0,1'b0,1'b1,1'b0,8'd2);
    addVec("pRun",     2'b10,3'b011,3'b001,1'b0,1'b0,1'b0,1'b0,3'b000,3'b000,1'b0,1'b0, 3'b000,2'b10,1'b0,1'b0,1'b0,1'b0,8'd2);
    addVec("tmrCount", 2'b10,3'b011,3'b001,1'b0,1'b0,1'b0,1'b0,3'b000,3'b000,1'b0,1'b1, 3'b000,2'b10,1'b0,1'b0,1'b0,1'b0,8'd3);
    addVec("dEnd",     2'b10,3'b011,3'b001,1'b0,1'b0,1'b1,1'b0,3'b000,3'b000,1'b0,1'b0, 3'b000,2'b10,1'b0,1'b0,1'b0,1'b0,8'd3);
    addVec("dIdle",    2'b10,3'b011,3'b001,1'b0,1'b0,1'b0,1'b0,3'b000,3'b011,1'b0,1'b0, 3'b000,2'b00,1'b0,1'b1,1'b0,1'b0,8'd3);

    // Reset values, including the combinational debug-enable term
    #12;
    checkOutput("inReset", 3'b000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    critical_section_i = 1'b1;
    #1;
    checkOutput("inResetCrit", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    resetDut();

    foreach (tbl[i]) begin
      applyStimulus(tbl[i]);
      step();
      checkOutput(tbl[i].name, tbl[i].eReq, tbl[i].eLe, tbl[i].eBoot, tbl[i].eExt,
                  tbl[i].eRec, tbl[i].eFault, tbl[i].eErr);
    end

    // DMR mask with three harts is rejected; fault survives the return to IDLE
    resetDut();
    safe_configuration_i = 2'b10; safe_mode_i = 3'b111; start_i = 1'b1;
    step();
    checkOutput("badMask", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    step();
    checkOutput("faultHold", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    start_i = 1'b0;
    step();
    checkOutput("faultIdle", 3'b000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 8'd0);

    // SINGLE with a non-one-hot master faults; a one-hot master is halted alone
    resetDut();
    safe_configuration_i = 2'b00; master_core_i = 3'b011; start_i = 1'b1;
    step();
    checkOutput("badMaster", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    resetDut();
    safe_configuration_i = 2'b00; master_core_i = 3'b100; start_i = 1'b1;
    step();
    checkOutput("singleHalt", 3'b100, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    // Hart 2 never halts: FAULT exactly 16 cycles after HALT entry
    resetDut();
    start_i = 1'b1;
    step();
    start_i = 1'b0; debug_mode_i = 3'b011;
    for (int k = 1; k <= 16; k++) begin
      step();
      if (k == 15) checkOutput("toBefore", 3'b111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      if (k == 16) checkOutput("toFault", 3'b000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0);
    end

    // Exit condition arriving on the expiry cycle reaches SYNC instead
    resetDut();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      debug_mode_i = (k == 16) ? 3'b111 : 3'b000;
      step();
      if (k == 16) checkOutput("toExitWins", 3'b111, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    end

    // 300 TMR error pulses in RUN saturate the counter without leaving RUN
    resetDut();
    start_i = 1'b1;
    step();
    start_i = 1'b0; debug_mode_i = 3'b111;
    step();
    initial_sync_master_i = 1'b1;
    step();
    initial_sync_master_i = 1'b0; debug_mode_i = 3'b000;
    step();
    checkOutput("satRun", 3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
    for (int i = 0; i < 300; i++) begin
      tmr_error_i = 1'b1;
      step();
      tmr_error_i = 1'b0;
      step();
    end
    checkOutput("saturate", 3'b000, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 8'd255);

    // Asynchronous reset in SYNC drops outputs at once; a new start restarts from HALT
    resetDut();
    start_i = 1'b1;
    step();
    start_i = 1'b0; debug_mode_i = 3'b111;
    step();
    checkOutput("preRst", 3'b111, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
    #3;
    rst_ni = 1'b0;
    #1;
    checkOutput("rstLow", 3'b000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    step();
    checkOutput("rstHeld", 3'b000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
    rst_ni = 1'b1; debug_mode_i = 3'b000; start_i = 1'b1;
    step();
    checkOutput("restart", 3'b111, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/safe_lockstep_fsm.md
# safe_lockstep_fsm

Internal sequencing FSM of the safe wrapper, downstream of the wrapper control register block. It consumes the configuration and command levels from the control registers (master core, DMR mask, safe configuration, start, end-of-routine, initial-sync, critical section). It drives the hart debug requests and the voter/comparator enables that move the harts into and out of lockstep. It also reports boot, debug-enable and DMR-recovery status back to the control registers.

## Interface
- NHARTS, 3: number of harts; fixed at 3 (TMR requires it).
- TIMEOUT_CYCLES, 1024: cycles allowed in any wait state before FAULT.
- ERRCNT_W, 8: width of the saturating error counter.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- master_core_i  in  3  one-hot master hart
- safe_mode_i  in  3  DMR hart mask
- safe_configuration_i  in  2  00 SINGLE, 01 TMR, 10 DMR, 11 reserved
- critical_section_i  in  1  software critical section active
- initial_sync_master_i  in  1  master finished context save
- start_i  in  1  start-lockstep level
- end_sw_routine_i  in  1  end-of-routine level
- debug_mode_i  in  NHARTS  per-hart debug-mode status
- sleep_i  in  NHARTS  per-hart WFI/sleep status
- dmr_error_i  in  1  DMR comparator mismatch
- tmr_error_i  in  1  TMR voter disagreement
- debug_req_o  out  NHARTS  per-hart debug halt request
- lockstep_en_o  out  2  active mode to voter: 00 off, 01 TMR, 10 DMR
- start_boot_o  out  1  sync phase in progress
- en_ext_debug_o  out  1  external debugger permitted
- dmr_rec_o  out  1  DMR recovery in progress
- fault_o  out  1  sticky sequencing fault
- err_count_o  out  ERRCNT_W  saturating count of DMR/TMR error events

## Operation
- Participating mask M is latched on leaving IDLE:
  - TMR: 3'b111.
  - DMR: safe_mode_i. Popcount other than 2 → FAULT.
  - SINGLE or 11: master_core_i. Not one-hot → FAULT.
- The FSM consumes the rising edges of start_i and end_sw_routine_i, detected with an internal flop each. Levels are ignored.
- States:
  - IDLE: start rise → HALT.
  - HALT: debug_req_o = M. Proceeds to SYNC when (debug_mode_i & M) == M.
  - SYNC: debug_req_o = M, start_boot_o = 1. Proceeds to RELEASE when initial_sync_master_i = 1.
  - RELEASE: debug_req_o = 0. Proceeds to RUN when (debug_mode_i & M) == 0.
  - RUN: lockstep_en_o = config; SINGLE gives 00.
    - end rise → DRAIN.
    - dmr_error_i rise with config DMR → HALT, with dmr_rec_o set.
    - dmr_error_i or tmr_error_i otherwise: count only.
  - DRAIN: lockstep_en_o held. Proceeds to IDLE when (sleep_i & M) == M.
  - FAULT: all debug_req_o low, lockstep_en_o = 00, fault_o = 1. Proceeds to IDLE when start_i = 0. fault_o stays set until reset.
- dmr_rec_o is set on entering HALT from RUN and cleared on entering RUN.
- en_ext_debug_o = 1 only in IDLE with critical_section_i = 0.
- Priority in RUN when events coincide: dmr recovery over end rise.
- A start rise outside IDLE is ignored.
- err_count_o increments by 1 per rising edge of (dmr_error_i | tmr_error_i) in any state and saturates at all-ones. A simultaneous DMR and TMR edge counts once.
- Timeout:
  - The counter clears on every state entry and runs in HALT, SYNC, RELEASE and DRAIN.
  - When it reaches TIMEOUT_CYCLES-1 without the exit condition, the next state is FAULT.
  - An exit condition true on the expiry cycle wins.

## Timing
- All outputs are Moore-decoded from registered state; there is no combinational input→output path. Exceptions:
  - en_ext_debug_o, which also ANDs in critical_section_i.
  - err_count_o, which is a flop.
- A start rise sampled at edge N → state HALT after N → debug_req_o high in cycle N+1.
- Every condition-driven transition takes effect at the edge where the condition is sampled true; there is one cycle of latency per state.
- Minimum IDLE→RUN time is 4 cycles with harts responding immediately.
- Reset values:
  - state IDLE, M = 0.
  - debug_req_o 0, lockstep_en_o 00, start_boot_o 0, dmr_rec_o 0, fault_o 0, err_count_o 0.
  - edge flops 0.
  - en_ext_debug_o = !critical_section_i.
- Asynchronous reset mid-sequence drops debug_req_o and lockstep_en_o immediately; there is no graceful drain.

## Structure
- The package safe_lockstep_pkg holds:
  - the state enum (IDLE, HALT, SYNC, RELEASE, RUN, DRAIN, FAULT);
  - the configuration encodings SAFE_SINGLE, SAFE_TMR, SAFE_DMR;
  - the lockstep_en encodings.
- Sub-module safe_lockstep_timer: a clearable up-counter with an expiry flag, parameterised by TIMEOUT_CYCLES.

## Test plan
- TMR normal flow:
  - Stimulus: config 01, start rise; harts raise debug_mode 2 cycles after debug_req; initial_sync pulses; harts leave debug.
  - Expected: debug_req_o 111 → 000, start_boot_o high only in SYNC, lockstep_en_o = 01, end rise plus sleep 111 → IDLE, lockstep_en_o = 00.
- DMR recovery:
  - Stimulus: config 10, safe_mode 011, in RUN pulse dmr_error_i.
  - Expected: next cycle dmr_rec_o = 1, debug_req_o = 011, err_count_o = 1; after re-sync RUN with dmr_rec_o = 0.
- Bad DMR mask:
  - Stimulus: safe_mode 111 with config 10, start rise.
  - Expected: FAULT, fault_o = 1, debug_req_o = 0; start low → IDLE, fault_o still 1.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES = 16, hart 2 never enters debug.
  - Expected: FAULT exactly 16 cycles after HALT entry. A variant where the exit condition arrives on the expiry cycle must reach SYNC instead.
- Counter saturation:
  - Stimulus: 300 tmr_error_i pulses in TMR RUN with ERRCNT_W = 8.
  - Expected: err_count_o = 255, state stays RUN.
- Reset mid-SYNC:
  - Stimulus: assert rst_ni low during SYNC.
  - Expected: all outputs at reset values while rst_ni is low; a later start rise restarts from HALT.
